// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment display path: segment patterns
// ({g,f,e,d,c,b,a}, active-high) and an elaboration-time clog2.
package disp_pkg;

   localparam logic [6:0] SEG_0   = 7'h3F;
   localparam logic [6:0] SEG_1   = 7'h06;
   localparam logic [6:0] SEG_2   = 7'h5B;
   localparam logic [6:0] SEG_3   = 7'h4F;
   localparam logic [6:0] SEG_4   = 7'h66;
   localparam logic [6:0] SEG_5   = 7'h6D;
   localparam logic [6:0] SEG_6   = 7'h7D;
   localparam logic [6:0] SEG_7   = 7'h07;
   localparam logic [6:0] SEG_8   = 7'h7F;
   localparam logic [6:0] SEG_9   = 7'h6F;
   localparam logic [6:0] SEG_A   = 7'h77;
   localparam logic [6:0] SEG_B   = 7'h7C;
   localparam logic [6:0] SEG_C   = 7'h39;
   localparam logic [6:0] SEG_D   = 7'h5E;
   localparam logic [6:0] SEG_E   = 7'h79;
   localparam logic [6:0] SEG_F   = 7'h71;
   localparam logic [6:0] SEG_OFF = 7'h00;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment lookup (active-high segments).
module seg7_decode
   import disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // nibble to segment pattern lookup
   always_comb begin
      seg = SEG_OFF;
      case (nibble)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         4'hF:    seg = SEG_F;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/digit_scan_mux.sv
// Multiplexed seven-segment scanner: prescaled digit scan, frame-synchronous
// shadow of the digit/dot inputs, leading-zero blanking, duty control, polarity.
module digit_scan_mux
   import disp_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int SCAN_LOG2  = 10,
   parameter int DUTY_BITS  = 3,
   parameter bit ACTIVE_LOW = 1'b0
)
(
   input  logic                    clk,
   input  logic                    hard_reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dot_mask,
   input  logic                    blank_lz,
   input  logic [DUTY_BITS-1:0]    brightness,
   output logic [3:0]              a,
   output logic [6:0]              seg,
   output logic                    dot,
   output logic [NUM_DIGITS-1:0]   seg_sel,
   output logic                    frame_start
);

   localparam int                    IDX_W     = clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [SCAN_LOG2-1:0]  PRESC_MAX = {SCAN_LOG2{1'b1}};
   localparam logic [6:0]            SEG_POL   = {7{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] SEL_POL   = {NUM_DIGITS{ACTIVE_LOW}};

   logic [SCAN_LOG2-1:0]    presc_r;
   logic [IDX_W-1:0]        idx_r;
   logic [4*NUM_DIGITS-1:0] sh_digits_r;
   logic [NUM_DIGITS-1:0]   sh_dots_r;
   logic                    run_r;

   logic                    tick_s;
   logic                    wrap_s;
   logic [3:0]              nibble_s;
   logic [6:0]              dec_s;
   logic                    dot_s;
   logic [NUM_DIGITS-1:0]   zero_above_s;
   logic                    blank_s;
   logic [DUTY_BITS-1:0]    slot_s;
   logic                    lit_s;
   logic [NUM_DIGITS-1:0]   onehot_s;

   logic [3:0]              next_a_s;
   logic [6:0]              next_seg_s;
   logic                    next_dot_s;
   logic [NUM_DIGITS-1:0]   next_sel_s;
   logic                    next_fs_s;

   assign tick_s   = (presc_r == PRESC_MAX);
   assign wrap_s   = tick_s && (idx_r == LAST_IDX);
   assign nibble_s = sh_digits_r[{idx_r, 2'b00} +: 4];
   assign dot_s    = sh_dots_r[idx_r];
   assign slot_s   = presc_r[SCAN_LOG2-1 -: DUTY_BITS];
   assign lit_s    = (slot_s <= brightness);
   assign onehot_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r;

   seg7_decode u_decode (
      .nibble (nibble_s),
      .seg    (dec_s)
   );

   // zero_above_s[k]: shadow digits k..NUM_DIGITS-1 are all zero
   always_comb begin
      zero_above_s = {NUM_DIGITS{1'b0}};
      for (int k = 0; k < NUM_DIGITS; k++) begin
         zero_above_s[k] = ((sh_digits_r >> (4 * k)) == {(4*NUM_DIGITS){1'b0}});
      end
   end

   assign blank_s = blank_lz && (idx_r != {IDX_W{1'b0}}) && zero_above_s[idx_r];

   // next output values, before polarity; idle until the shadow has loaded
   always_comb begin
      next_a_s   = 4'h0;
      next_seg_s = SEG_OFF;
      next_dot_s = 1'b0;
      next_sel_s = {NUM_DIGITS{1'b0}};
      next_fs_s  = 1'b0;
      if (run_r) begin
         next_a_s   = nibble_s;
         next_seg_s = blank_s ? SEG_OFF : dec_s;
         next_dot_s = dot_s;
         if (lit_s && (!blank_s || dot_s)) begin
            next_sel_s = onehot_s;
         end else begin
            next_sel_s = {NUM_DIGITS{1'b0}};
         end
         next_fs_s  = (idx_r == {IDX_W{1'b0}}) && (presc_r == {SCAN_LOG2{1'b0}});
      end else begin
         next_a_s   = 4'h0;
         next_seg_s = SEG_OFF;
         next_dot_s = 1'b0;
         next_sel_s = {NUM_DIGITS{1'b0}};
         next_fs_s  = 1'b0;
      end
   end

   // scan state: the first cycle out of reset only loads the shadow
   always_ff @(posedge clk or posedge hard_reset) begin
      if (hard_reset) begin
         presc_r     <= {SCAN_LOG2{1'b0}};
         idx_r       <= {IDX_W{1'b0}};
         sh_digits_r <= {(4*NUM_DIGITS){1'b0}};
         sh_dots_r   <= {NUM_DIGITS{1'b0}};
         run_r       <= 1'b0;
      end else if (!run_r) begin
         run_r       <= 1'b1;
         sh_digits_r <= digits;
         sh_dots_r   <= dot_mask;
      end else begin
         presc_r <= presc_r + SCAN_LOG2'(1);
         if (wrap_s) begin
            idx_r       <= {IDX_W{1'b0}};
            sh_digits_r <= digits;
            sh_dots_r   <= dot_mask;
         end else if (tick_s) begin
            idx_r <= idx_r + IDX_W'(1);
         end
      end
   end

   // output register with pin polarity applied
   always_ff @(posedge clk or posedge hard_reset) begin
      if (hard_reset) begin
         a           <= 4'h0;
         seg         <= SEG_POL;
         dot         <= ACTIVE_LOW;
         seg_sel     <= SEL_POL;
         frame_start <= 1'b0;
      end else begin
         a           <= next_a_s;
         seg         <= next_seg_s ^ SEG_POL;
         dot         <= next_dot_s ^ ACTIVE_LOW;
         seg_sel     <= next_sel_s ^ SEL_POL;
         frame_start <= next_fs_s;
      end
   end

endmodule
